// File: rtl/rv_branch_ctrl.sv
// EX-stage branch resolution and redirect sequencer with a 2-bit BHT.
// Resolves branches/JAL/JALR, compares against the carried prediction, and redirects IF on mispredict.
module rv_branch_ctrl #(
    parameter int unsigned BUS_W   = 32,
    parameter int unsigned BHT_IDX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] if_pc,
    output logic             if_predTaken,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [1:0]       ex_kind,
    input  logic [2:0]       ex_branchOp,
    input  logic [BUS_W-1:0] ex_srcA,
    input  logic [BUS_W-1:0] ex_srcB,
    input  logic [BUS_W-1:0] ex_pc,
    input  logic [BUS_W-1:0] ex_imm,
    input  logic             ex_predTaken,
    output logic             redirect_valid,
    output logic [BUS_W-1:0] redirect_pc,
    input  logic             redirect_ready,
    output logic             flush,
    output logic [15:0]      branch_cnt,
    output logic [15:0]      mispredict_cnt
);

    localparam int unsigned BHT_N = 1 << BHT_IDX;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] REDIRECT = 1'b1;

    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_BR   = 2'b01;
    localparam logic [1:0] KIND_JAL  = 2'b10;
    localparam logic [1:0] KIND_JALR = 2'b11;

    logic [0:0]       state_q, state_d;
    logic [BUS_W-1:0] redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic [15:0]      branch_cnt_q, branch_cnt_d;
    logic [15:0]      mispredict_cnt_q, mispredict_cnt_d;
    logic [1:0]       bht_q [BHT_N];
    logic [1:0]       bht_d [BHT_N];

    logic               accept;
    logic               is_ctrl;
    logic               cmp_eq, cmp_lt_s, cmp_lt_u;
    logic               br_taken;
    logic               taken;
    logic               mispredict;
    logic [BUS_W-1:0]   pc_plus_imm;
    logic [BUS_W-1:0]   pc_plus_4;
    logic [BUS_W-1:0]   jalr_sum;
    logic [BUS_W-1:0]   taken_target;
    logic [BUS_W-1:0]   resolved_target;
    logic [BHT_IDX-1:0] rd_idx;
    logic [BHT_IDX-1:0] upd_idx;
    logic               unused_bits;

    assign rd_idx  = if_pc[BHT_IDX+1:2];
    assign upd_idx = ex_pc[BHT_IDX+1:2];

    // Reads the registered table, so a same-cycle update is only seen next cycle.
    assign if_predTaken = bht_q[rd_idx][1];

    assign accept  = ex_valid && (state_q == IDLE);
    assign is_ctrl = (ex_kind != KIND_NONE);

    assign cmp_eq   = (ex_srcA == ex_srcB);
    assign cmp_lt_s = ($signed(ex_srcA) < $signed(ex_srcB));
    assign cmp_lt_u = (ex_srcA < ex_srcB);

    always_comb begin
        br_taken = 1'b0;
        case (ex_branchOp)
            3'b000:  br_taken = cmp_eq;
            3'b001:  br_taken = !cmp_eq;
            3'b100:  br_taken = cmp_lt_s;
            3'b101:  br_taken = !cmp_lt_s;
            3'b110:  br_taken = cmp_lt_u;
            3'b111:  br_taken = !cmp_lt_u;
            default: br_taken = 1'b0;
        endcase
    end

    assign pc_plus_imm = ex_pc + ex_imm;
    assign pc_plus_4   = ex_pc + BUS_W'(4);
    assign jalr_sum    = ex_srcA + ex_imm;

    always_comb begin
        taken        = 1'b0;
        mispredict   = 1'b0;
        taken_target = pc_plus_imm;
        case (ex_kind)
            KIND_BR: begin
                taken      = br_taken;
                mispredict = (br_taken != ex_predTaken);
            end
            KIND_JAL: begin
                taken      = 1'b1;
                mispredict = !ex_predTaken;
            end
            KIND_JALR: begin
                taken        = 1'b1;
                mispredict   = 1'b1;
                taken_target = {jalr_sum[BUS_W-1:1], 1'b0};
            end
            default: begin
                taken      = 1'b0;
                mispredict = 1'b0;
            end
        endcase
    end

    assign resolved_target = taken ? taken_target : pc_plus_4;

    always_comb begin
        state_d          = state_q;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = 1'b0;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && is_ctrl) begin
                    if (branch_cnt_q != '1) begin
                        branch_cnt_d = branch_cnt_q + 16'd1;
                    end
                    if (mispredict) begin
                        state_d       = REDIRECT;
                        redirect_pc_d = resolved_target;
                        flush_d       = 1'b1;
                        if (mispredict_cnt_q != '1) begin
                            mispredict_cnt_d = mispredict_cnt_q + 16'd1;
                        end
                    end
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bht_d = bht_q;
        if (accept && (ex_kind == KIND_BR)) begin
            if (br_taken) begin
                if (bht_q[upd_idx] != 2'b11) begin
                    bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
                end
            end else begin
                if (bht_q[upd_idx] != 2'b00) begin
                    bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
            for (int unsigned i = 0; i < BHT_N; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            state_q          <= state_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            bht_q            <= bht_d;
        end
    end

    assign ex_ready       = (state_q == IDLE);
    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

    assign unused_bits = ^{if_pc[BUS_W-1:BHT_IDX+2], if_pc[1:0], jalr_sum[0]};

endmodule

// File: doc/rv_branch_ctrl.md
# rv_branch_ctrl

Branch resolution and redirect sequencer for the EX stage. Resolves conditional branches, JAL and JALR, and checks each outcome against the prediction carried down the pipe. On a mispredict it holds EX and drives a PC redirect plus a one-cycle flush to IF/ID. It also owns the 2-bit branch history table (BHT) that IF reads for its taken/not-taken prediction.

## Interface
Parameters:
- BUS_W, 32: datapath width (matches core `BUS_W`)
- BHT_IDX, 4: BHT index bits; table has 2^BHT_IDX entries, indexed by pc[BHT_IDX+1:2]

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_pc  in  BUS_W  fetch PC for BHT lookup
- if_predTaken  out  1  combinational; bit 1 of BHT[if_pc[BHT_IDX+1:2]]
- ex_valid  in  1  EX holds a valid instruction
- ex_ready  out  1  controller can accept; equals (state==IDLE)
- ex_kind  in  2  00 none, 01 cond branch, 10 JAL, 11 JALR
- ex_branchOp  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- ex_srcA, ex_srcB  in  BUS_W  rs1 / rs2 operands
- ex_pc, ex_imm  in  BUS_W  instruction PC, sign-extended immediate
- ex_predTaken  in  1  prediction used by IF for this instruction
- redirect_valid  out  1  new PC offered to IF
- redirect_pc  out  BUS_W  corrected fetch PC
- redirect_ready  in  1  IF accepts the redirect
- flush  out  1  kill younger instructions in IF/ID
- branch_cnt  out  16  accepted control instructions, saturating
- mispredict_cnt  out  16  issued redirects, saturating

## Operation
- **States:** IDLE, REDIRECT.
- **Accept:** an instruction is accepted when ex_valid && ex_ready. An accepted kind 00 has no effect.

Resolution of an accepted control instruction (all arithmetic modulo 2^BUS_W):
- Branch: taken from the funct3 compare; signed for BLT/BGE, unsigned for BLTU/BGEU.
- Branch, funct3 010 or 011: not taken. It is still counted and still updates the BHT.
- JAL and JALR: always taken.
- Taken target: JAL and branch use ex_pc+ex_imm. JALR uses (ex_srcA+ex_imm) with bit 0 cleared.
- Not-taken target: ex_pc+4.

Mispredict rules:
- Branch: taken != ex_predTaken.
- JAL: !ex_predTaken.
- JALR: always.

State transitions:
- IDLE, accept with mispredict: latch redirect_pc = resolved target (taken target, or ex_pc+4 if not taken), then go to REDIRECT.
- IDLE, otherwise: stay in IDLE.
- REDIRECT: redirect_valid=1 and ex_ready=0. flush=1 only in the first REDIRECT cycle. Return to IDLE on the edge where redirect_ready=1.

BHT:
- Each entry is a 2-bit saturating counter. Updated only on an accepted kind 01, at the accept edge, at index ex_pc[BHT_IDX+1:2].
- Taken increments (saturates at 3); not taken decrements (saturates at 0).

Counters:
- branch_cnt +1 on every accepted kind != 00.
- mispredict_cnt +1 on every IDLE→REDIRECT transition.
- Both hold at 0xFFFF.

Reset (async):
- state=IDLE.
- Every BHT entry = 2'b01 (weakly not-taken).
- redirect_valid=0, flush=0, redirect_pc=0, branch_cnt=0, mispredict_cnt=0.
- ex_ready=1 once reset is released.

## Timing
- Accept at edge N → redirect_valid and flush high in cycle N+1. flush drops at N+2 even if redirect_ready stays 0.
- redirect_ready=1 in cycle N+1 → one-cycle redirect; ex_ready=1 again in N+2.
- redirect_ready low: redirect_valid and redirect_pc hold stable until accepted.
- Correctly predicted control instructions never stall: back-to-back accepts every cycle.
- BHT read/write collision (if_pc index == update index in the same cycle): if_predTaken shows the pre-update value; the new value is visible next cycle.
- ex_kind, operands and prediction are sampled only on the accept cycle. They are ignored in REDIRECT.
- Reset asserted during REDIRECT: redirect_valid and flush drop immediately (async) and the pending redirect is discarded.

## Test plan
- **Correct prediction, no stall:** BEQ, srcA=srcB=5, pc=0x100, imm=0x20, predTaken=1 → no redirect, flush=0, ex_ready stays 1, branch_cnt=1, BHT[0] goes 01→10.
- **Not-taken mispredict:** BLT, srcA=0xFFFFFFFF, srcB=1, predTaken=0, pc=0x200, imm=0x40 → next cycle redirect_valid=1, redirect_pc=0x240, flush=1 for one cycle, mispredict_cnt=1.
- **Unsigned compare, backpressure:** BLTU, srcA=0xFFFFFFFF, srcB=1, predTaken=1, pc=0x300 → redirect_pc=0x304. Hold redirect_ready=0 for 3 cycles → redirect_valid held, flush high only in the first cycle, ex_ready=0 throughout.
- **JALR alignment:** srcA=0x1001, imm=0x10 → redirect_pc=0x1010 (bit 0 cleared). JAL with predTaken=1 → no redirect.
- **BHT saturation and collision:** 4 taken branches at pc=0x40 → entry saturates at 3. Drive if_pc=0x40 in the update cycle → if_predTaken shows the old value; new value seen next cycle.
- **Reset mid-redirect:** assert rst in REDIRECT → redirect_valid=0, flush=0 immediately. After release: counters 0, all BHT entries predict not-taken, ex_ready=1.
